// File: rtl/pcie_x1_sym_pkg.sv
// Shared symbol constants and FSM encoding for the x1 byte-wide lane Tx path.
//   K_* / D_IDL : 8b symbol codes (K codes are only meaningful with the K flag set)
//   PEND_MAX    : saturation value of the pending-SKP-set counter (2-bit)
//   state_t     : SKP scheduler FSM states
//   is_pkt_start / is_pkt_end : packet framing decode on an accepted symbol
package pcie_x1_sym_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] D_IDL = 8'h00;

  localparam int PEND_MAX = 3;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SKP = 1'b1
  } state_t;

  function automatic logic is_pkt_start(input logic [7:0] data, input logic kcntl);
    return kcntl && (data == K_STP || data == K_SDP);
  endfunction

  function automatic logic is_pkt_end(input logic [7:0] data, input logic kcntl);
    return kcntl && (data == K_END || data == K_EDB);
  endfunction

endpackage

// File: rtl/pcie_x1_skp_sched_if.sv
// Symbol stream between the upstream symbol mux, the SKP scheduler and the PCS Tx.
//   in_data/in_kcntl/in_valid : upstream symbol offered to the scheduler
//   in_ready                  : scheduler accepts the offered symbol this cycle
//   out_data/out_kcntl        : registered symbol towards the PCS
// master = upstream/PCS side (bench), slave = scheduler.
interface pcie_x1_skp_sched_if;
  logic [7:0] in_data;
  logic       in_kcntl;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_kcntl;

  modport master (
    output in_data, in_kcntl, in_valid,
    input  in_ready, out_data, out_kcntl
  );

  modport slave (
    input  in_data, in_kcntl, in_valid,
    output in_ready, out_data, out_kcntl
  );
endinterface

// File: rtl/pcie_x1_skp_interval_cnt.sv
// SKP interval counter and pending-set bookkeeping.
//   clk_in, rst_n : symbol clock, async active-low reset
//   skp_disable   : hold counter at 0, drop forces, clear pending (except mid-set)
//   skp_force     : one extra set request
//   set_active    : a SKP set is being emitted; pending is kept so it can finish
//   dec           : the set in flight has emitted its last SKP
//   pend_cnt      : saturating count of sets still owed
//   skp_overrun   : registered pulse when a request was lost to saturation
module pcie_x1_skp_interval_cnt
  import pcie_x1_sym_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_W        = 11
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       skp_disable,
  input  logic       skp_force,
  input  logic       set_active,
  input  logic       dec,
  output logic [1:0] pend_cnt,
  output logic       skp_overrun
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic [2:0]       base;
  logic [2:0]       req;
  logic [2:0]       net;
  logic [1:0]       pend_nxt;
  logic             overrun_nxt;

  assign wrap = (cnt == CNT_W'(SKP_INTERVAL - 1));

  // Decrement is applied before the new requests, then the sum saturates.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    base        = {1'b0, pend_cnt};
    req         = '0;
    net         = '0;
    pend_nxt    = pend_cnt;
    overrun_nxt = 1'b0;
    if (dec && pend_cnt != 2'd0) base = base - 3'd1;
    if (skp_disable) begin
      pend_nxt = set_active ? base[1:0] : 2'd0;
    end else begin
      req = {2'b00, wrap} + {2'b00, skp_force};
      net = base + req;
      if (net > 3'(PEND_MAX)) begin
        pend_nxt    = 2'(PEND_MAX);
        overrun_nxt = 1'b1;
      end else begin
        pend_nxt = net[1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: this block holds only a handful of control flops, so all of them take
  // the async reset; there is no storage array that would need to skip it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pend_cnt    <= '0;
      skp_overrun <= 1'b0;
    end else begin
      if (skp_disable || wrap) cnt <= '0;
      else                     cnt <= cnt + CNT_W'(1);
      pend_cnt    <= pend_nxt;
      skp_overrun <= overrun_nxt;
    end
  end

endmodule

// File: rtl/pcie_x1_skp_sched.sv
// Tx-side SKP ordered-set scheduler for the x1 byte-wide lane.
// Inserts COM + NUM_SKP x SKP into the symbol stream at packet boundaries
// once a set is owed, stalling the upstream while the set is emitted.
//   clk_in, rst_n  : symbol clock, async active-low reset
//   skp_disable    : stop scheduling (a set in flight still completes)
//   skp_force      : request one extra set
//   sym (slave)    : upstream symbol in / registered symbol out
//   skp_sent       : pulse aligned with COM on sym.out_data
//   skp_pending    : at least one set owed
//   skp_overrun    : set request lost to saturation
//   tx_underrun    : upstream went idle inside a packet
module pcie_x1_skp_sched
  import pcie_x1_sym_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int NUM_SKP      = 3,
  parameter int CNT_W        = 11
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               skp_disable,
  input  logic               skp_force,
  pcie_x1_skp_sched_if.slave sym,
  output logic               skp_sent,
  output logic               skp_pending,
  output logic               skp_overrun,
  output logic               tx_underrun
);

  localparam logic [2:0] IDX_LAST = 3'(NUM_SKP - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       in_pkt, in_pkt_nxt;
  logic [1:0] pend_cnt;
  logic       start_set;
  logic       ready;
  logic       accept;
  logic       dec;
  logic [7:0] data_nxt;
  logic       kcntl_nxt;
  logic       sent_nxt;
  logic       underrun_nxt;

  pcie_x1_skp_interval_cnt #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_interval_cnt (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .skp_disable (skp_disable),
    .skp_force   (skp_force),
    .set_active  (state == ST_SKP),
    .dec         (dec),
    .pend_cnt    (pend_cnt),
    .skp_overrun (skp_overrun)
  );

  // A set may only start between packets; mid-packet it waits for END/EDB.
  assign start_set   = (pend_cnt != 2'd0) && !in_pkt;
  assign sym.in_ready = rst_n && ready;
  assign accept      = sym.in_valid && ready;
  assign skp_pending = (pend_cnt != 2'd0);

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    data_nxt     = D_IDL;
    kcntl_nxt    = 1'b0;
    sent_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    dec          = 1'b0;
    ready        = 1'b0;
    case (state)
      ST_RUN: begin
        ready = !start_set;
        if (start_set) begin
          data_nxt  = K_COM;
          kcntl_nxt = 1'b1;
          sent_nxt  = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_SKP;
        end else if (sym.in_valid) begin
          data_nxt  = sym.in_data;
          kcntl_nxt = sym.in_kcntl;
        end else if (in_pkt) begin
          underrun_nxt = 1'b1;
        end
      end
      ST_SKP: begin
        data_nxt  = K_SKP;
        kcntl_nxt = 1'b1;
        idx_nxt   = idx + 3'd1;
        if (idx == IDX_LAST) begin
          dec       = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    in_pkt_nxt = in_pkt;
    if (accept && is_pkt_start(sym.in_data, sym.in_kcntl))    in_pkt_nxt = 1'b1;
    else if (accept && is_pkt_end(sym.in_data, sym.in_kcntl)) in_pkt_nxt = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      idx           <= '0;
      in_pkt        <= 1'b0;
      sym.out_data  <= D_IDL;
      sym.out_kcntl <= 1'b0;
      skp_sent      <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      in_pkt        <= in_pkt_nxt;
      sym.out_data  <= data_nxt;
      sym.out_kcntl <= kcntl_nxt;
      skp_sent      <= sent_nxt;
      tx_underrun   <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_pcie_x1_skp_sched.sv
// Self-checking bench for pcie_x1_skp_sched (SKP_INTERVAL = 16, NUM_SKP = 3).
// The reference model tracks owed sets as an integer and the set in flight as
// a queue of symbols still to be emitted.
module tb_pcie_x1_skp_sched;

  localparam int INTERVAL = 16;
  localparam int NSKP     = 3;

  localparam logic [8:0] S_COM = {1'b1, 8'hBC};
  localparam logic [8:0] S_SKP = {1'b1, 8'h1C};
  localparam logic [8:0] S_STP = {1'b1, 8'hFB};
  localparam logic [8:0] S_SDP = {1'b1, 8'h5C};
  localparam logic [8:0] S_END = {1'b1, 8'hFD};
  localparam logic [8:0] S_EDB = {1'b1, 8'hFE};

  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       k;
    logic       sent;
    logic       under;
    logic       ovr;
    logic       pend;
  } obs_t;

  logic clk_in = 1'b0;
  logic rst_n;
  logic skp_disable;
  logic skp_force;
  logic skp_sent;
  logic skp_pending;
  logic skp_overrun;
  logic tx_underrun;

  pcie_x1_skp_sched_if sym ();

  pcie_x1_skp_sched #(
    .SKP_INTERVAL (INTERVAL),
    .NUM_SKP      (NSKP),
    .CNT_W        (11)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .skp_disable (skp_disable),
    .skp_force   (skp_force),
    .sym         (sym),
    .skp_sent    (skp_sent),
    .skp_pending (skp_pending),
    .skp_overrun (skp_overrun),
    .tx_underrun (tx_underrun)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  int         m_cnt;
  int         m_pend;
  logic       m_in_pkt;
  logic [8:0] m_set_q[$];

  task automatic model_reset();
    m_cnt    = 0;
    m_pend   = 0;
    m_in_pkt = 1'b0;
    m_set_q.delete();
  endtask

  task automatic model_step(input logic vld, input logic [7:0] d, input logic k,
                            input logic dis, input logic frc, output obs_t e);
    logic busy;
    logic dec;
    int   req;
    int   base;
    int   tot;
    e    = '0;
    dec  = 1'b0;
    busy = (m_set_q.size() != 0);
    if (busy) begin
      {e.k, e.data} = m_set_q.pop_front();
      if (m_set_q.size() == 0) dec = 1'b1;
    end else if (m_pend > 0 && !m_in_pkt) begin
      {e.k, e.data} = S_COM;
      e.sent = 1'b1;
      for (int i = 0; i < NSKP; i++) m_set_q.push_back(S_SKP);
    end else begin
      e.rdy = 1'b1;
      if (vld) begin
        e.data = d;
        e.k    = k;
        if ({k, d} == S_STP || {k, d} == S_SDP)      m_in_pkt = 1'b1;
        else if ({k, d} == S_END || {k, d} == S_EDB) m_in_pkt = 1'b0;
      end else if (m_in_pkt) begin
        e.under = 1'b1;
      end
    end
    req = 0;
    if (dis) begin
      m_cnt = 0;
    end else begin
      if (m_cnt == INTERVAL - 1) begin
        m_cnt = 0;
        req++;
      end else begin
        m_cnt++;
      end
      if (frc) req++;
    end
    base = m_pend - (dec ? 1 : 0);
    if (base < 0) base = 0;
    if (dis) begin
      m_pend = busy ? base : 0;
    end else begin
      tot = base + req;
      if (tot > 3) begin
        e.ovr  = 1'b1;
        m_pend = 3;
      end else begin
        m_pend = tot;
      end
    end
    e.pend = (m_pend != 0);
  endtask

  // One symbol time: drive, sample in_ready, clock, sample registered outputs.
  task automatic step(input logic vld, input logic [7:0] d, input logic k,
                      input logic dis, input logic frc, output obs_t o, output obs_t e);
    sym.in_valid = vld;
    sym.in_data  = d;
    sym.in_kcntl = k;
    skp_disable  = dis;
    skp_force    = frc;
    #1;
    o     = '0;
    o.rdy = sym.in_ready;
    model_step(vld, d, k, dis, frc, e);
    @(posedge clk_in);
    #1;
    cyc++;
    o.data  = sym.out_data;
    o.k     = sym.out_kcntl;
    o.sent  = skp_sent;
    o.under = tx_underrun;
    o.ovr   = skp_overrun;
    o.pend  = skp_pending;
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    sym.in_valid = 1'b0;
    sym.in_data  = 8'h00;
    sym.in_kcntl = 1'b0;
    skp_disable  = 1'b0;
    skp_force    = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sym.in_valid = 1'b1;
    sym.in_data  = 8'hFB;
    sym.in_kcntl = 1'b1;
    skp_disable  = 1'b0;
    skp_force    = 1'b1;
    #1;
    checks++;
    if (sym.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=0", sym.in_ready);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if ({sym.out_kcntl, sym.out_data} !== 9'h000) begin
      errors++;
      $display("FAIL reset_out got=%h exp=000", {sym.out_kcntl, sym.out_data});
    end
    checks++;
    if ({skp_sent, skp_pending, skp_overrun, tx_underrun} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {skp_sent, skp_pending, skp_overrun, tx_underrun});
    end
    apply_reset();
  endtask

  task automatic test_idle_stream();
    obs_t o, e;
    int   sent_at[$];
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL idle_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (o.sent) sent_at.push_back(cyc);
      if (cyc >= 18 && cyc <= 20) begin
        checks++;
        if ({o.k, o.data} !== S_SKP) begin
          errors++;
          $display("FAIL idle_skp cyc=%0d got=%h exp=%h", cyc, {o.k, o.data}, S_SKP);
        end
      end
    end
    checks++;
    if (sent_at.size() != 2) begin
      errors++;
      $display("FAIL idle_sent_count got=%0d exp=2", sent_at.size());
    end else if (sent_at[0] != 17 || sent_at[1] != 33) begin
      errors++;
      $display("FAIL idle_sent_cycles got=%0d,%0d exp=17,33", sent_at[0], sent_at[1]);
    end
  endtask

  task automatic test_tlp();
    obs_t       o, e;
    logic [8:0] pkt[40];
    logic [8:0] got[$];
    logic       vld;
    int         p = 0;
    int         refused = 0;
    int         fd_cyc = -1;
    int         bc_cyc = -1;
    int         bad = 0;
    apply_reset();
    pkt[0]  = S_STP;
    pkt[39] = S_END;
    for (int i = 1; i < 39; i++) pkt[i] = {1'b0, 8'($urandom)};
    for (int i = 1; i <= 60; i++) begin
      vld = (i >= 10 && p < 40);
      step(vld, vld ? pkt[p][7:0] : 8'h00, vld ? pkt[p][8] : 1'b0, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL tlp_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (vld) begin
        if (o.rdy) begin
          got.push_back({o.k, o.data});
          if (p == 39) fd_cyc = cyc;
          p++;
        end else begin
          refused++;
        end
      end
      if (o.sent && bc_cyc < 0) bc_cyc = cyc;
    end
    checks++;
    if (refused != 0) begin
      errors++;
      $display("FAIL tlp_refused got=%0d exp=0", refused);
    end
    checks++;
    if (got.size() != 40) begin
      errors++;
      $display("FAIL tlp_count got=%0d exp=40", got.size());
    end else begin
      for (int i = 0; i < 40; i++) if (got[i] !== pkt[i]) bad++;
      if (bad != 0) begin
        errors++;
        $display("FAIL tlp_order mismatched=%0d exp=0", bad);
      end
    end
    checks++;
    if (fd_cyc < 0 || bc_cyc != fd_cyc + 1) begin
      errors++;
      $display("FAIL tlp_com_after_end got=%0d exp=%0d", bc_cyc, fd_cyc + 1);
    end
  endtask

  task automatic test_long_packet();
    obs_t       o, e;
    logic [8:0] log_q[0:127];
    logic [8:0] cur;
    logic       vld;
    int         fd_cyc = -1;
    int         ovr_cnt = 0;
    int         bad = 0;
    apply_reset();
    for (int i = 1; i <= 90; i++) begin
      vld = (i <= 70);
      if (i == 1)       cur = S_STP;
      else if (i == 70) cur = S_EDB;
      else              cur = {1'b0, 8'($urandom)};
      step(vld, cur[7:0], vld ? cur[8] : 1'b0, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL long_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      log_q[cyc] = {o.k, o.data};
      if (o.ovr) ovr_cnt++;
      if (vld && o.rdy && i == 70) fd_cyc = cyc;
    end
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL long_overrun_pulses got=%0d exp=1", ovr_cnt);
    end
    checks++;
    if (fd_cyc != 70) begin
      errors++;
      $display("FAIL long_end_accept got=%0d exp=70", fd_cyc);
    end else begin
      for (int j = 0; j < 12; j++)
        if (log_q[71 + j] !== ((j % 4 == 0) ? S_COM : S_SKP)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL long_three_sets mismatched=%0d exp=0", bad);
      end
    end
  endtask

  task automatic test_force_wrap();
    obs_t       o, e;
    logic [8:0] log_q[0:63];
    logic       pend_log[0:63];
    int         ovr_cnt = 0;
    int         bad = 0;
    apply_reset();
    for (int i = 1; i <= 26; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, i == 16, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL force_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      log_q[cyc]    = {o.k, o.data};
      pend_log[cyc] = o.pend;
      if (o.ovr) ovr_cnt++;
    end
    for (int j = 0; j < 8; j++)
      if (log_q[17 + j] !== ((j % 4 == 0) ? S_COM : S_SKP)) bad++;
    checks++;
    if (bad != 0 || ovr_cnt != 0) begin
      errors++;
      $display("FAIL force_two_sets mismatched=%0d overruns=%0d exp=0,0", bad, ovr_cnt);
    end
    checks++;
    if (pend_log[20] !== 1'b1 || pend_log[24] !== 1'b0) begin
      errors++;
      $display("FAIL force_pending got=%b%b exp=10", pend_log[20], pend_log[24]);
    end
  endtask

  task automatic test_disable_mid_set();
    obs_t o, e;
    int   late_sent = 0;
    apply_reset();
    for (int i = 1; i <= 125; i++) begin
      step(1'b0, 8'h00, 1'b0, i >= 19, i == 30, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dis_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (cyc == 20) begin
        checks++;
        if ({o.k, o.data} !== S_SKP || o.pend !== 1'b0) begin
          errors++;
          $display("FAIL dis_third_skp got=%h pend=%b exp=%h pend=0", {o.k, o.data}, o.pend, S_SKP);
        end
      end
      if (cyc > 20 && (o.sent || o.pend)) late_sent++;
    end
    checks++;
    if (late_sent != 0) begin
      errors++;
      $display("FAIL dis_no_more_sets got=%0d exp=0", late_sent);
    end
  endtask

  task automatic test_underrun_and_reset();
    obs_t       o, e;
    logic [8:0] cur;
    logic       vld;
    int         under_at = -1;
    int         under_cnt = 0;
    int         sent_at = -1;
    apply_reset();
    for (int i = 1; i <= 18; i++) begin
      vld = (i >= 2 && i <= 11 && i != 8);
      if (i == 2)       cur = S_STP;
      else if (i == 11) cur = S_END;
      else              cur = {1'b0, 8'($urandom_range(1, 255))};
      step(vld, cur[7:0], vld ? cur[8] : 1'b0, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL under_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (o.under) begin
        under_cnt++;
        under_at = cyc;
      end
      if (o.sent) sent_at = cyc;
    end
    checks++;
    if (under_cnt != 1 || under_at != 8) begin
      errors++;
      $display("FAIL underrun_pulse count=%0d at=%0d exp=1 at 8", under_cnt, under_at);
    end
    checks++;
    if (sent_at != 17) begin
      errors++;
      $display("FAIL under_com_cycle got=%0d exp=17", sent_at);
    end
    // async reset while the set is still being emitted
    rst_n        = 1'b0;
    sym.in_valid = 1'b1;
    #1;
    checks++;
    if ({sym.in_ready, sym.out_kcntl, sym.out_data, skp_sent, skp_pending} !== 12'h000) begin
      errors++;
      $display("FAIL midset_reset got=%h exp=000",
               {sym.in_ready, sym.out_kcntl, sym.out_data, skp_sent, skp_pending});
    end
    @(posedge clk_in);
    #1;
    checks++;
    if ({sym.in_ready, sym.out_kcntl, sym.out_data} !== 10'h000) begin
      errors++;
      $display("FAIL midset_reset_hold got=%h exp=000", {sym.in_ready, sym.out_kcntl, sym.out_data});
    end
    model_reset();
    cyc   = 0;
    rst_n = 1'b1;
    sent_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (o.sent && sent_at < 0) sent_at = cyc;
    end
    checks++;
    if (sent_at != 17) begin
      errors++;
      $display("FAIL post_reset_com got=%0d exp=17", sent_at);
    end
  endtask

  task automatic test_random_traffic();
    obs_t       o, e;
    logic [8:0] cur = '0;
    logic       have = 1'b0;
    int         left = 0;
    int         dis_left = 0;
    logic       frc;
    apply_reset();
    for (int i = 0; i < 900; i++) begin
      if (!have) begin
        if (left > 0) begin
          if ($urandom_range(0, 9) != 0) begin
            left--;
            if (left == 0) cur = $urandom_range(0, 1) ? S_END : S_EDB;
            else           cur = {1'b0, 8'($urandom)};
            have = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          left = $urandom_range(3, 50);
          cur  = $urandom_range(0, 1) ? S_STP : S_SDP;
          have = 1'b1;
        end
      end
      if (dis_left > 0) dis_left--;
      else if ($urandom_range(0, 299) == 0) dis_left = $urandom_range(1, 30);
      frc = ($urandom_range(0, 39) == 0);
      step(have, cur[7:0], cur[8], dis_left > 0, frc, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (have && o.rdy) have = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    sym.in_valid = 1'b0;
    sym.in_data  = 8'h00;
    sym.in_kcntl = 1'b0;
    skp_disable  = 1'b0;
    skp_force    = 1'b0;
    model_reset();
    test_reset();
    test_idle_stream();
    test_tlp();
    test_long_packet();
    test_force_wrap();
    test_disable_mid_set();
    test_underrun_and_reset();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
